sng_cmp_bank: RTL and testbench

- Stochastic number generator (SNG) stage directly downstream of the Sobol RNG (the one-dimensional Sobol generator followed by its shift-register lane duplication).
- Latches NUM_RNG binary operands and controls the RNG enable.
- Compares each operand against its RNG lane every cycle and emits one unary bitstream bit per lane for exactly 2^INWD cycles.
- Feeds the stochastic compute array (fc layer datapath).

---
 rtl/sng_pkg.sv | 28 ++
 rtl/sng_if.sv | 32 +++
 rtl/sng_lane.sv | 52 +++++
 rtl/sng_cmp_bank.sv | 113 +++++++++++
 tb/tb_sng_cmp_bank.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sng_pkg.sv
// Shared types and build-time defaults for the stochastic number generator bank.
// NUM_RNG / INWD default from the `NUM_RNG / `INWD macros when the build provides them.
`default_nettype none

`ifndef NUM_RNG
`define NUM_RNG 4
`endif
`ifndef INWD
`define INWD 8
`endif

package sng_pkg;
  localparam int DEF_NUM_RNG = `NUM_RNG;
  localparam int DEF_INWD    = `INWD;
  localparam int STREAM_LEN  = 1 << DEF_INWD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WARM  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } sng_state_e;

  typedef logic [DEF_INWD-1:0] op_t;
  typedef op_t op_vec_t [DEF_NUM_RNG];
endpackage

`default_nettype wire

// File: rtl/sng_if.sv
// Operand handshake, RNG hookup and bitstream bus of the SNG bank.
// The popcnt signal exists only when SNG_POPCNT_EN is defined.
`default_nettype none

interface sng_if #(
  parameter int NUM_RNG = sng_pkg::DEF_NUM_RNG,
  parameter int INWD    = sng_pkg::DEF_INWD
);
  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_RNG*INWD-1:0]   in_op;
  logic [NUM_RNG*INWD-1:0]   rng_seq;
  logic                      rng_en;
  logic [NUM_RNG-1:0]        bs_out;
  logic                      bs_valid;
  logic                      bs_last;
`ifdef SNG_POPCNT_EN
  logic [NUM_RNG*(INWD+1)-1:0] popcnt;

  modport master (output in_valid, in_op, rng_seq,
                  input  in_ready, rng_en, bs_out, bs_valid, bs_last, popcnt);
  modport slave  (input  in_valid, in_op, rng_seq,
                  output in_ready, rng_en, bs_out, bs_valid, bs_last, popcnt);
`else
  modport master (output in_valid, in_op, rng_seq,
                  input  in_ready, rng_en, bs_out, bs_valid, bs_last);
  modport slave  (input  in_valid, in_op, rng_seq,
                  output in_ready, rng_en, bs_out, bs_valid, bs_last);
`endif
endinterface

`default_nettype wire

// File: rtl/sng_lane.sv
// One SNG lane: registered operand-vs-RNG compare and, with SNG_POPCNT_EN,
// a ones counter over the emitted stream.
`default_nettype none

module sng_lane
  import sng_pkg::*;
#(
  parameter int INWD = DEF_INWD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmp_en_i,
  input  logic [INWD-1:0] op_i,
  input  logic [INWD-1:0] rng_i,
`ifdef SNG_POPCNT_EN
  input  logic            clr_i,
  input  logic            bs_valid_i,
  output logic [INWD:0]   popcnt_o,
`endif
  output logic            bs_o
);
  logic bs_q;

  // Outside RUN the bit is forced low so FLUSH/IDLE never show stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bs_q <= 1'b0;
    end else begin
      bs_q <= cmp_en_i && (op_i > rng_i);
    end
  end

  assign bs_o = bs_q;

`ifdef SNG_POPCNT_EN
  logic [INWD:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (bs_valid_i && bs_q) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign popcnt_o = cnt_q;
`endif
endmodule

`default_nettype wire

// File: rtl/sng_cmp_bank.sv
// SNG bank: latches NUM_RNG operands, warms up the Sobol RNG, then emits a
// 2^INWD-bit unary stream per lane. Optional per-lane popcount: SNG_POPCNT_EN.
`default_nettype none

module sng_cmp_bank
  import sng_pkg::*;
#(
  parameter int NUM_RNG  = DEF_NUM_RNG,
  parameter int INWD     = DEF_INWD,
  parameter int WARM_CYC = 2 + DEF_NUM_RNG
) (
  input logic clk,
  input logic rst_n,
  sng_if.slave bus
);
  localparam int WW = (WARM_CYC > 1) ? $clog2(WARM_CYC) : 1;

  sng_state_e              state_q, state_d;
  logic [NUM_RNG*INWD-1:0] op_q, op_d;
  logic [WW-1:0]           warm_cnt_q, warm_cnt_d;
  logic [INWD-1:0]         run_cnt_q, run_cnt_d;
  logic                    bs_valid_q, bs_last_q;
  logic                    accept;
  logic                    run_last;
  logic [NUM_RNG-1:0]      bs_w;

  assign accept   = bus.in_valid && (state_q == IDLE);
  assign run_last = (state_q == RUN) && (&run_cnt_q);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    warm_cnt_d = warm_cnt_q;
    run_cnt_d  = run_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d       = bus.in_op;
          warm_cnt_d = '0;
          run_cnt_d  = '0;
          state_d    = (WARM_CYC == 0) ? RUN : WARM;
        end
      end
      WARM: begin
        warm_cnt_d = warm_cnt_q + 1'b1;
        if (int'(warm_cnt_q) == WARM_CYC - 1) begin
          run_cnt_d = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        // INWD-bit counter wraps to 0 on the final bit by construction.
        run_cnt_d = run_cnt_q + 1'b1;
        if (&run_cnt_q) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      warm_cnt_q <= '0;
      run_cnt_q  <= '0;
      bs_valid_q <= 1'b0;
      bs_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      warm_cnt_q <= warm_cnt_d;
      run_cnt_q  <= run_cnt_d;
      bs_valid_q <= (state_q == RUN);
      bs_last_q  <= run_last;
    end
  end

`ifdef SNG_POPCNT_EN
  logic [NUM_RNG*(INWD+1)-1:0] popcnt_w;
  assign bus.popcnt = popcnt_w;
`endif

  for (genvar i = 0; i < NUM_RNG; i++) begin : g_lane
    sng_lane #(.INWD(INWD)) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmp_en_i   (state_q == RUN),
      .op_i       (op_q[i*INWD +: INWD]),
      .rng_i      (bus.rng_seq[i*INWD +: INWD]),
`ifdef SNG_POPCNT_EN
      .clr_i      (accept),
      .bs_valid_i (bs_valid_q),
      .popcnt_o   (popcnt_w[i*(INWD+1) +: INWD+1]),
`endif
      .bs_o       (bs_w[i])
    );
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.rng_en   = (state_q == WARM) || (state_q == RUN);
  assign bus.bs_out   = bs_w;
  assign bus.bs_valid = bs_valid_q;
  assign bus.bs_last  = bs_last_q;
endmodule

`default_nettype wire

// File: tb/tb_sng_cmp_bank.sv
// Scoreboard bench for sng_cmp_bank: expected lane counts are queued at
// operand drive time and compared when each stream completes.
`default_nettype none

module tb_sng_cmp_bank;
  import sng_pkg::*;

  localparam int N    = DEF_NUM_RNG;
  localparam int W    = DEF_INWD;
  localparam int WARM = 2 + N;
  localparam int LEN  = STREAM_LEN;

  typedef logic [N-1:0][W-1:0] ovec_t;
  typedef struct packed {
    int                 acc_edge;
    int                 first_valid;
    int                 rng_first;
    int                 rng_cnt;
    int                 len;
    int                 last_pos;
    int                 last_cnt;
    logic               rng_in_flush;
    logic [N-1:0][31:0] ones;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   vec = 0;
  int   errs = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sng_if #(.NUM_RNG(N), .INWD(W)) bus ();
  sng_if #(.NUM_RNG(N), .INWD(W)) bus0 ();

  sng_cmp_bank #(.NUM_RNG(N), .INWD(W), .WARM_CYC(WARM)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  sng_cmp_bank #(.NUM_RNG(N), .INWD(W), .WARM_CYC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));

  // Reference RNG: bit-reversed Gray code (1-D Sobol order) plus lane shift chain.
  function automatic logic [W-1:0] sobol(input logic [W-1:0] k);
    logic [W-1:0] g;
    logic [W-1:0] r;
    g = k ^ (k >> 1);
    for (int b = 0; b < W; b++) r[b] = g[W-1-b];
    return r;
  endfunction

  logic [W-1:0] k_a, k_b;
  logic [W-1:0] ln_a [N];
  logic [W-1:0] ln_b [N];

  always @(posedge clk) begin
    if (!rst_n) begin
      k_a <= '0;
      k_b <= '0;
      for (int i = 0; i < N; i++) begin
        ln_a[i] <= '0;
        ln_b[i] <= '0;
      end
    end else begin
      if (bus.rng_en) begin
        k_a     <= k_a + 1'b1;
        ln_a[0] <= sobol(k_a);
        for (int i = 1; i < N; i++) ln_a[i] <= ln_a[i-1];
      end
      if (bus0.rng_en) begin
        k_b     <= k_b + 1'b1;
        ln_b[0] <= sobol(k_b);
        for (int i = 1; i < N; i++) ln_b[i] <= ln_b[i-1];
      end
    end
  end

  always_comb begin
    bus.rng_seq  = '0;
    bus0.rng_seq = '0;
    for (int i = 0; i < N; i++) begin
      bus.rng_seq[i*W +: W]  = ln_a[i];
      bus0.rng_seq[i*W +: W] = ln_b[i];
    end
  end

  ovec_t  exp_q [$];
  frame_t obs_q [$];
  frame_t cur;
  bit     active = 1'b0;

  // Monitor: gathers one record per completed stream, sampled on negedge.
  initial begin
    cur = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
        cur    = '0;
      end else if (bus.in_valid && bus.in_ready) begin
        cur             = '0;
        cur.acc_edge    = cyc + 1;
        cur.first_valid = -1;
        cur.rng_first   = -1;
        active          = 1'b1;
      end else if (active) begin
        if (bus.rng_en) begin
          if (cur.rng_first < 0) cur.rng_first = cyc;
          cur.rng_cnt++;
        end
        if (bus.bs_valid) begin
          if (cur.first_valid < 0) cur.first_valid = cyc;
          cur.len++;
          for (int i = 0; i < N; i++) cur.ones[i] = cur.ones[i] + 32'(bus.bs_out[i]);
        end
        if (bus.bs_last) begin
          cur.last_cnt++;
          cur.last_pos = bus.bs_valid ? cur.len : -1;
        end
        if (bus.bs_last && bus.bs_valid) begin
          cur.rng_in_flush = bus.rng_en;
          obs_q.push_back(cur);
          active = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input ovec_t ops);
    int n = 0;
    while (!bus.in_ready && n < 2000) begin tick(); n++; end
    bus.in_op    = ops;
    bus.in_valid = 1'b1;
    exp_q.push_back(ops);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Returns in the IDLE cycle right after FLUSH, when popcnt is final.
  task automatic wait_frame(output frame_t f, output bit ok);
    int n = 0;
    while (obs_q.size() == 0 && n < 2000) begin tick(); n++; end
    ok = (obs_q.size() != 0);
    f  = ok ? obs_q.pop_front() : '0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus0.in_valid = 1'b0;
    bus0.in_op    = '0;
    repeat (3) tick();
    vec++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    vec++; if (bus.rng_en !== 1'b0) begin errs++; $display("FAIL reset_rng_en: got %b want 0", bus.rng_en); end
    vec++; if (bus.bs_valid !== 1'b0) begin errs++; $display("FAIL reset_bs_valid: got %b want 0", bus.bs_valid); end
    vec++; if (bus.bs_last !== 1'b0) begin errs++; $display("FAIL reset_bs_last: got %b want 0", bus.bs_last); end
    vec++; if (bus.bs_out !== '0) begin errs++; $display("FAIL reset_bs_out: got %h want 0", bus.bs_out); end
`ifdef SNG_POPCNT_EN
    vec++; if (bus.popcnt !== '0) begin errs++; $display("FAIL reset_popcnt: got %h want 0", bus.popcnt); end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    frame_t f;
    bit     ok;
    ovec_t  e;
    send({8'd37, 8'd128, 8'd255, 8'd0});
    wait_frame(f, ok);
    e = exp_q.pop_front();
    vec++; if (!ok) begin errs++; $display("FAIL stream_timeout: got none want frame"); end
    vec++; if (f.len !== LEN) begin errs++; $display("FAIL stream_len: got %0d want %0d", f.len, LEN); end
    vec++; if (f.last_pos !== LEN || f.last_cnt !== 1) begin errs++; $display("FAIL stream_last: pos %0d cnt %0d want %0d 1", f.last_pos, f.last_cnt, LEN); end
    vec++; if (f.first_valid - f.acc_edge !== WARM + 1) begin errs++; $display("FAIL stream_latency: got %0d want %0d", f.first_valid - f.acc_edge, WARM + 1); end
    vec++; if (f.rng_first !== f.acc_edge) begin errs++; $display("FAIL rng_rise: got %0d want %0d", f.rng_first, f.acc_edge); end
    vec++; if (f.rng_cnt !== WARM + LEN) begin errs++; $display("FAIL rng_cnt: got %0d want %0d", f.rng_cnt, WARM + LEN); end
    vec++; if (f.rng_in_flush !== 1'b0) begin errs++; $display("FAIL rng_flush: got %b want 0", f.rng_in_flush); end
    vec++; if (bus.rng_en !== 1'b0) begin errs++; $display("FAIL rng_idle: got %b want 0", bus.rng_en); end
    vec++; if (f.len - int'(f.ones[1]) !== 1) begin errs++; $display("FAIL lane1_zeros: got %0d want 1", f.len - int'(f.ones[1])); end
    for (int i = 0; i < N; i++) begin
      vec++; if (f.ones[i] !== 32'(e[i])) begin errs++; $display("FAIL stream_ones[%0d]: got %0d want %0d", i, f.ones[i], e[i]); end
`ifdef SNG_POPCNT_EN
      vec++; if (bus.popcnt[i*(W+1) +: W+1] !== {1'b0, e[i]}) begin errs++; $display("FAIL stream_popcnt[%0d]: got %0d want %0d", i, bus.popcnt[i*(W+1) +: W+1], e[i]); end
`endif
    end
  endtask

  task automatic test_handshake();
    frame_t f1, f2;
    bit     ok1, ok2;
    ovec_t  e;
    int     n = 0;
    while (!bus.in_ready && n < 2000) begin tick(); n++; end
    bus.in_op    = {8'd90, 8'd17, 8'd3, 8'd250};
    bus.in_valid = 1'b1;
    exp_q.push_back({8'd90, 8'd17, 8'd3, 8'd250});
    tick();
    repeat (60) tick();
    bus.in_op = '1;
    repeat (100) tick();
    bus.in_op = {8'd5, 8'd66, 8'd199, 8'd128};
    exp_q.push_back({8'd5, 8'd66, 8'd199, 8'd128});
    wait_frame(f1, ok1);
    tick();
    bus.in_valid = 1'b0;
    repeat (50) tick();
    bus.in_op = '0;
    wait_frame(f2, ok2);
    vec++; if (!(ok1 && ok2)) begin errs++; $display("FAIL hs_timeout: got %0d%0d want 11", ok1, ok2); end
    vec++; if (f2.acc_edge - f1.acc_edge !== WARM + LEN + 2) begin errs++; $display("FAIL hs_spacing: got %0d want %0d", f2.acc_edge - f1.acc_edge, WARM + LEN + 2); end
    e = exp_q.pop_front();
    for (int i = 0; i < N; i++) begin
      vec++; if (f1.ones[i] !== 32'(e[i])) begin errs++; $display("FAIL hs_f1_ones[%0d]: got %0d want %0d", i, f1.ones[i], e[i]); end
    end
    e = exp_q.pop_front();
    for (int i = 0; i < N; i++) begin
      vec++; if (f2.ones[i] !== 32'(e[i])) begin errs++; $display("FAIL hs_f2_ones[%0d]: got %0d want %0d", i, f2.ones[i], e[i]); end
    end
  endtask

  task automatic test_reset_mid_run();
    frame_t f;
    bit     ok;
    ovec_t  e;
    int     n = 0;
    send({8'd9, 8'd9, 8'd9, 8'd9});
    while (cur.len < 100 && n < 2000) begin tick(); n++; end
    #2;
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_front());
    vec++; if (bus.bs_valid !== 1'b0) begin errs++; $display("FAIL abort_bs_valid: got %b want 0", bus.bs_valid); end
    vec++; if (bus.rng_en !== 1'b0) begin errs++; $display("FAIL abort_rng_en: got %b want 0", bus.rng_en); end
    vec++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL abort_in_ready: got %b want 1", bus.in_ready); end
    vec++; if (bus.bs_last !== 1'b0) begin errs++; $display("FAIL abort_bs_last: got %b want 0", bus.bs_last); end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    vec++; if (obs_q.size() !== 0) begin errs++; $display("FAIL abort_no_last: got %0d frames want 0", obs_q.size()); end
    send({8'd4, 8'd3, 8'd2, 8'd1});
    wait_frame(f, ok);
    e = exp_q.pop_front();
    vec++; if (!ok) begin errs++; $display("FAIL post_abort_timeout: got none want frame"); end
    for (int i = 0; i < N; i++) begin
      vec++; if (f.ones[i] !== 32'(e[i])) begin errs++; $display("FAIL post_abort_ones[%0d]: got %0d want %0d", i, f.ones[i], e[i]); end
`ifdef SNG_POPCNT_EN
      vec++; if (bus.popcnt[i*(W+1) +: W+1] !== {1'b0, e[i]}) begin errs++; $display("FAIL post_abort_popcnt[%0d]: got %0d want %0d", i, bus.popcnt[i*(W+1) +: W+1], e[i]); end
`endif
    end
  endtask

  task automatic test_back_to_back();
    frame_t f1, f2;
    bit     ok1, ok2;
    ovec_t  e;
    send({8'd203, 8'd202, 8'd201, 8'd200});
    wait_frame(f1, ok1);
    e = exp_q.pop_front();
    for (int i = 0; i < N; i++) begin
      vec++; if (f1.ones[i] !== 32'(e[i])) begin errs++; $display("FAIL b2b_f1_ones[%0d]: got %0d want %0d", i, f1.ones[i], e[i]); end
`ifdef SNG_POPCNT_EN
      vec++; if (bus.popcnt[i*(W+1) +: W+1] !== {1'b0, e[i]}) begin errs++; $display("FAIL b2b_f1_popcnt[%0d]: got %0d want %0d", i, bus.popcnt[i*(W+1) +: W+1], e[i]); end
`endif
    end
    send({8'd53, 8'd52, 8'd51, 8'd50});
    wait_frame(f2, ok2);
    e = exp_q.pop_front();
    vec++; if (!(ok1 && ok2)) begin errs++; $display("FAIL b2b_timeout: got %0d%0d want 11", ok1, ok2); end
    vec++; if (f2.acc_edge - f1.acc_edge !== WARM + LEN + 2) begin errs++; $display("FAIL b2b_spacing: got %0d want %0d", f2.acc_edge - f1.acc_edge, WARM + LEN + 2); end
    for (int i = 0; i < N; i++) begin
      vec++; if (f2.ones[i] !== 32'(e[i])) begin errs++; $display("FAIL b2b_f2_ones[%0d]: got %0d want %0d", i, f2.ones[i], e[i]); end
    end
  endtask

  task automatic test_warm0();
    int  lat = 0;
    int  len = 0;
    bit  last_seen = 1'b0;
    int  n = 0;
    while (!bus0.in_ready && n < 2000) begin tick(); n++; end
    bus0.in_op    = {8'd40, 8'd30, 8'd20, 8'd10};
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    while (!bus0.bs_valid && lat < 50) begin tick(); lat++; end
    while (bus0.bs_valid && len < 2000) begin
      len++;
      if (bus0.bs_last) last_seen = 1'b1;
      tick();
    end
    vec++; if (lat !== 1) begin errs++; $display("FAIL warm0_latency: got %0d want 1", lat); end
    vec++; if (len !== LEN) begin errs++; $display("FAIL warm0_len: got %0d want %0d", len, LEN); end
    vec++; if (last_seen !== 1'b1) begin errs++; $display("FAIL warm0_last: got %b want 1", last_seen); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_handshake();
    test_reset_mid_run();
    test_back_to_back();
    test_warm0();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule

`default_nettype wire
